id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage for the pipelined MIPS core. It sits directly downstream of the opcode decoder in the decode stage. It registers the decoded control bundle with the operands, immediate, PC+4 and register numbers, and resolves the destination register (rt, rd or $31). It also detects load-use hazards, stalling the front end and inserting bubbles, and it squashes the decode-stage instruction on a flush from branch/jump resolution.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of operand, immediate and PC+4 fields.
- `CNT_WIDTH`, 16: width of the bubble counter.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `Flush` in 1: squash the instruction currently in decode (taken branch/jump).
- `ID_Jump, ID_RegDst, ID_BranchEQ, ID_BranchNE, ID_MemRead, ID_MemtoReg, ID_MemWrite, ID_ALUSrc, ID_RegWrite` in 1 each: decoded control.
- `ID_ALUOp` in 3: ALU operation code.
- `ID_Rs, ID_Rt, ID_Rd` in 5: instruction register fields.
- `ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_PC4` in DATA_WIDTH: decode-stage data.
- `EX_*` out: registered copies of every control and data input above, same widths.
- `EX_WriteReg` out 5: resolved destination register.
- `EX_Valid` out 1: 1 = real instruction, 0 = bubble.
- `Stall` out 1: combinational; 1 = PC and IF/ID must hold.
- `BubbleCount` out CNT_WIDTH: saturating count of inserted bubbles.

## Operation
- Hazard, combinational: `Hazard = EX_MemRead & EX_Valid & (EX_Rt != 0) & (EX_Rt == ID_Rs | EX_Rt == ID_Rt)`.
  - Both source fields are compared for every opcode. This is conservative and intentional.
- `Stall = Hazard & ~Flush`. Flush has priority because the dependent instruction is being discarded.
- Per rising edge, exactly one of the following applies:
  - **Flush = 1:** load a bubble.
  - **Else Hazard = 1:** load a bubble.
  - **Else:** load all ID_* inputs and set EX_Valid = 1.
- Bubble:
  - Loads EX_Valid = 0 and zeroes all control outputs: Jump, RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp = 000.
  - Data fields and register numbers still load the ID_* values. They carry no meaning.
  - EX_WriteReg = 0.
- Destination, evaluated on the ID inputs:
  - ID_Jump & ID_RegWrite (JAL): 31.
  - Else ID_RegDst: ID_Rd.
  - Else: ID_Rt.
- BubbleCount increments by 1 on each edge that loads a bubble. It saturates at all-ones and does not wrap.
- A stall always lasts exactly one cycle. The bubble clears EX_MemRead, so Hazard drops next cycle. Back-to-back loads each stall at most once.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs. Stall has zero latency: it is combinational on the EX registers and the ID inputs.
- Reset (reset = 0, asynchronous):
  - All EX_* outputs, EX_WriteReg, EX_Valid and BubbleCount go to 0.
  - Stall therefore reads 0.
  - Reset asserted mid-stall discards the pending bubble. After release, the first edge loads the held decode instruction normally.
- Simultaneous Flush and Hazard: one bubble, Stall = 0, BubbleCount +1 (not +2).
- Upstream sees Stall during the hazard cycle and holds PC and IF/ID across the following edge.
- No ready/valid handshake beyond Stall and Flush.

## Configuration
- `ID_EX_HAZARD_DETECT_EN` defined: hazard logic as described above.
- Not defined:
  - Hazard is tied to 0, so Stall is constant 0.
  - Bubbles come only from Flush, and BubbleCount counts flushes only.
  - Software must schedule a nop after every load whose result is used by the next instruction.

## Test plan
- **Reset:** drive non-zero inputs, assert reset between edges -> all outputs 0 immediately, without waiting for a clock edge.
- **R-type pass-through:** add, rs=1 rt=2 rd=3, RegDst=1, RegWrite=1, ALUOp=111 -> next edge: EX_WriteReg=3, EX_ALUOp=111, EX_Valid=1, Stall=0.
- **Load-use (macro defined):**
  - Send lw $8, then add rs=8 -> Stall=1 for one cycle, then a bubble (EX_Valid=0, EX_RegWrite=0), BubbleCount=1.
  - The add then appears on the next edge.
- **Load to $0:** lw $0, then add rs=0 -> Stall=0, no bubble.
- **Flush with hazard:** lw $5 in EX, ID rt=5, Flush=1 -> Stall=0, one bubble, BubbleCount +1.
- **JAL:** Jump=1, RegWrite=1, RegDst=0, rt=7 -> EX_WriteReg=31.
- **Saturation:** preload BubbleCount to 16'hFFFF via forced flushes, flush once more -> stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: 1-cycle latency, resolves the destination register and counts inserted bubbles.
// Backpressure: combinational Stall holds PC and IF/ID for one cycle on a load-use hazard, and Flush squashes decode.
// Load-use detection is built only when ID_EX_HAZARD_DETECT_EN is defined; otherwise Stall is tied low.
`timescale 1ns/1ps
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Flush,
  input  logic                  ID_Jump,
  input  logic                  ID_RegDst,
  input  logic                  ID_BranchEQ,
  input  logic                  ID_BranchNE,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemtoReg,
  input  logic                  ID_MemWrite,
  input  logic                  ID_ALUSrc,
  input  logic                  ID_RegWrite,
  input  logic [2:0]            ID_ALUOp,
  input  logic [4:0]            ID_Rs,
  input  logic [4:0]            ID_Rt,
  input  logic [4:0]            ID_Rd,
  input  logic [DATA_WIDTH-1:0] ID_ReadData1,
  input  logic [DATA_WIDTH-1:0] ID_ReadData2,
  input  logic [DATA_WIDTH-1:0] ID_SignExtImm,
  input  logic [DATA_WIDTH-1:0] ID_PC4,
  output logic                  EX_Jump,
  output logic                  EX_RegDst,
  output logic                  EX_BranchEQ,
  output logic                  EX_BranchNE,
  output logic                  EX_MemRead,
  output logic                  EX_MemtoReg,
  output logic                  EX_MemWrite,
  output logic                  EX_ALUSrc,
  output logic                  EX_RegWrite,
  output logic [2:0]            EX_ALUOp,
  output logic [4:0]            EX_Rs,
  output logic [4:0]            EX_Rt,
  output logic [4:0]            EX_Rd,
  output logic [DATA_WIDTH-1:0] EX_ReadData1,
  output logic [DATA_WIDTH-1:0] EX_ReadData2,
  output logic [DATA_WIDTH-1:0] EX_SignExtImm,
  output logic [DATA_WIDTH-1:0] EX_PC4,
  output logic [4:0]            EX_WriteReg,
  output logic                  EX_Valid,
  output logic                  Stall,
  output logic [CNT_WIDTH-1:0]  BubbleCount
);

  typedef struct packed {
    logic       jump;
    logic       regDst;
    logic       branchEq;
    logic       branchNe;
    logic       memRead;
    logic       memtoReg;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
    logic [2:0] aluOp;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic [DATA_WIDTH-1:0] signExtImm;
    logic [DATA_WIDTH-1:0] pc4;
  } data_t;

  ctrl_t idCtrl, exCtrl;
  data_t idData, exData;
  logic  [4:0] idWriteReg, exWriteReg;
  logic  exValid;
  logic  [CNT_WIDTH-1:0] bubbleCnt;
  logic  hazard;
  logic  loadBubble;

  assign idCtrl = '{jump: ID_Jump, regDst: ID_RegDst, branchEq: ID_BranchEQ,
                    branchNe: ID_BranchNE, memRead: ID_MemRead, memtoReg: ID_MemtoReg,
                    memWrite: ID_MemWrite, aluSrc: ID_ALUSrc, regWrite: ID_RegWrite,
                    aluOp: ID_ALUOp};

  assign idData = '{rs: ID_Rs, rt: ID_Rt, rd: ID_Rd, readData1: ID_ReadData1,
                    readData2: ID_ReadData2, signExtImm: ID_SignExtImm, pc4: ID_PC4};

`ifdef ID_EX_HAZARD_DETECT_EN
  // Both source fields are compared regardless of opcode; a spurious stall only costs a cycle.
  assign hazard = exCtrl.memRead & exValid & (exData.rt != 5'd0) &
                  ((exData.rt == ID_Rs) | (exData.rt == ID_Rt));
`else
  assign hazard = 1'b0;
`endif

  // Flush wins: the dependent instruction is being discarded, so upstream need not hold it.
  assign Stall      = hazard & ~Flush;
  assign loadBubble = Flush | hazard;

  always_comb begin
    idWriteReg = ID_Rt;
    if (ID_Jump && ID_RegWrite) begin
      idWriteReg = 5'd31;
    end else if (ID_RegDst) begin
      idWriteReg = ID_Rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exCtrl     <= '0;
      exData     <= '0;
      exWriteReg <= 5'd0;
      exValid    <= 1'b0;
      bubbleCnt  <= '0;
    end else begin
      exData <= idData;
      if (loadBubble) begin
        exCtrl     <= '0;
        exWriteReg <= 5'd0;
        exValid    <= 1'b0;
        if (bubbleCnt != {CNT_WIDTH{1'b1}}) begin
          bubbleCnt <= bubbleCnt + 1'b1;
        end
      end else begin
        exCtrl     <= idCtrl;
        exWriteReg <= idWriteReg;
        exValid    <= 1'b1;
      end
    end
  end

  assign EX_Jump       = exCtrl.jump;
  assign EX_RegDst     = exCtrl.regDst;
  assign EX_BranchEQ   = exCtrl.branchEq;
  assign EX_BranchNE   = exCtrl.branchNe;
  assign EX_MemRead    = exCtrl.memRead;
  assign EX_MemtoReg   = exCtrl.memtoReg;
  assign EX_MemWrite   = exCtrl.memWrite;
  assign EX_ALUSrc     = exCtrl.aluSrc;
  assign EX_RegWrite   = exCtrl.regWrite;
  assign EX_ALUOp      = exCtrl.aluOp;
  assign EX_Rs         = exData.rs;
  assign EX_Rt         = exData.rt;
  assign EX_Rd         = exData.rd;
  assign EX_ReadData1  = exData.readData1;
  assign EX_ReadData2  = exData.readData2;
  assign EX_SignExtImm = exData.signExtImm;
  assign EX_PC4        = exData.pc4;
  assign EX_WriteReg   = exWriteReg;
  assign EX_Valid      = exValid;
  assign BubbleCount   = bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; load-use expectations follow ID_EX_HAZARD_DETECT_EN.
`timescale 1ns/1ps
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  logic Flush;
  logic ID_Jump, ID_RegDst, ID_BranchEQ, ID_BranchNE, ID_MemRead;
  logic ID_MemtoReg, ID_MemWrite, ID_ALUSrc, ID_RegWrite;
  logic [2:0] ID_ALUOp;
  logic [4:0] ID_Rs, ID_Rt, ID_Rd;
  logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_PC4;
  logic EX_Jump, EX_RegDst, EX_BranchEQ, EX_BranchNE, EX_MemRead;
  logic EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_RegWrite;
  logic [2:0] EX_ALUOp;
  logic [4:0] EX_Rs, EX_Rt, EX_Rd, EX_WriteReg;
  logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_SignExtImm, EX_PC4;
  logic EX_Valid, Stall;
  logic [CW-1:0] BubbleCount;

  int nCompared = 0;
  int nMismatched = 0;
  int expCnt = 0;
  logic hazOn;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .Flush(Flush),
    .ID_Jump(ID_Jump), .ID_RegDst(ID_RegDst), .ID_BranchEQ(ID_BranchEQ),
    .ID_BranchNE(ID_BranchNE), .ID_MemRead(ID_MemRead), .ID_MemtoReg(ID_MemtoReg),
    .ID_MemWrite(ID_MemWrite), .ID_ALUSrc(ID_ALUSrc), .ID_RegWrite(ID_RegWrite),
    .ID_ALUOp(ID_ALUOp), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_SignExtImm(ID_SignExtImm), .ID_PC4(ID_PC4),
    .EX_Jump(EX_Jump), .EX_RegDst(EX_RegDst), .EX_BranchEQ(EX_BranchEQ),
    .EX_BranchNE(EX_BranchNE), .EX_MemRead(EX_MemRead), .EX_MemtoReg(EX_MemtoReg),
    .EX_MemWrite(EX_MemWrite), .EX_ALUSrc(EX_ALUSrc), .EX_RegWrite(EX_RegWrite),
    .EX_ALUOp(EX_ALUOp), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_SignExtImm(EX_SignExtImm), .EX_PC4(EX_PC4),
    .EX_WriteReg(EX_WriteReg), .EX_Valid(EX_Valid), .Stall(Stall),
    .BubbleCount(BubbleCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // c = {Jump, RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
  task automatic setInstr(input logic [8:0] c, input logic [2:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    {ID_Jump, ID_RegDst, ID_BranchEQ, ID_BranchNE, ID_MemRead,
     ID_MemtoReg, ID_MemWrite, ID_ALUSrc, ID_RegWrite} = c;
    ID_ALUOp      = op;
    ID_Rs         = rs;
    ID_Rt         = rt;
    ID_Rd         = rd;
    ID_ReadData1  = 32'hA000_0000 | 32'(rs);
    ID_ReadData2  = 32'hB000_0000 | 32'(rt);
    ID_SignExtImm = 32'hFFFF_FFF0 | 32'(rd);
    ID_PC4        = 32'h0040_0004;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [8:0] C_RTYPE = 9'b010000001;
  localparam logic [8:0] C_LW    = 9'b000011011;
  localparam logic [8:0] C_JAL   = 9'b100000001;

  initial begin
`ifdef ID_EX_HAZARD_DETECT_EN
    hazOn = 1'b1;
`else
    hazOn = 1'b0;
`endif
    reset = 1'b1;
    Flush = 1'b0;
    setInstr(C_LW, 3'b101, 5'd3, 5'd9, 5'd4);

    // Load non-zero state, then assert reset between edges.
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(EX_Valid), 32'd0);
    chk("rst_memread", 32'(EX_MemRead), 32'd0);
    chk("rst_rd1", EX_ReadData1, 32'd0);
    chk("rst_writereg", 32'(EX_WriteReg), 32'd0);
    chk("rst_cnt", 32'(BubbleCount), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // R-type add $3,$1,$2
    setInstr(C_RTYPE, 3'b111, 5'd1, 5'd2, 5'd3);
    tick();
    chk("r_writereg", 32'(EX_WriteReg), 32'd3);
    chk("r_aluop", 32'(EX_ALUOp), 32'd7);
    chk("r_valid", 32'(EX_Valid), 32'd1);
    chk("r_stall", 32'(Stall), 32'd0);
    chk("r_rd1", EX_ReadData1, 32'hA000_0001);

    // lw $8 then add using $8
    setInstr(C_LW, 3'b000, 5'd9, 5'd8, 5'd0);
    tick();
    chk("lw_writereg", 32'(EX_WriteReg), 32'd8);
    setInstr(C_RTYPE, 3'b111, 5'd8, 5'd2, 5'd4);
    #1;
    chk("lu_stall", 32'(Stall), 32'(hazOn));
    tick();
    if (hazOn) begin
      expCnt++;
      chk("lu_bub_valid", 32'(EX_Valid), 32'd0);
      chk("lu_bub_regwrite", 32'(EX_RegWrite), 32'd0);
      chk("lu_bub_writereg", 32'(EX_WriteReg), 32'd0);
      chk("lu_cnt", 32'(BubbleCount), 32'(expCnt));
      chk("lu_stall_drop", 32'(Stall), 32'd0);
      tick();
    end
    chk("lu_add_valid", 32'(EX_Valid), 32'd1);
    chk("lu_add_writereg", 32'(EX_WriteReg), 32'd4);
    chk("lu_add_cnt", 32'(BubbleCount), 32'(expCnt));

    // Load to $0 never stalls
    setInstr(C_LW, 3'b000, 5'd9, 5'd0, 5'd0);
    tick();
    setInstr(C_RTYPE, 3'b111, 5'd0, 5'd2, 5'd5);
    #1;
    chk("z_stall", 32'(Stall), 32'd0);
    tick();
    chk("z_valid", 32'(EX_Valid), 32'd1);
    chk("z_cnt", 32'(BubbleCount), 32'(expCnt));

    // Flush together with a hazard: one bubble, no stall
    setInstr(C_LW, 3'b000, 5'd9, 5'd5, 5'd0);
    tick();
    setInstr(C_RTYPE, 3'b111, 5'd1, 5'd5, 5'd6);
    Flush = 1'b1;
    #1;
    chk("fh_stall", 32'(Stall), 32'd0);
    tick();
    Flush = 1'b0;
    expCnt++;
    chk("fh_valid", 32'(EX_Valid), 32'd0);
    chk("fh_regwrite", 32'(EX_RegWrite), 32'd0);
    chk("fh_cnt", 32'(BubbleCount), 32'(expCnt));

    // JAL writes $31
    setInstr(C_JAL, 3'b000, 5'd0, 5'd7, 5'd2);
    tick();
    chk("jal_writereg", 32'(EX_WriteReg), 32'd31);
    chk("jal_jump", 32'(EX_Jump), 32'd1);

    // Reset asserted while a load-use stall is pending
    setInstr(C_LW, 3'b000, 5'd9, 5'd6, 5'd0);
    tick();
    setInstr(C_RTYPE, 3'b111, 5'd6, 5'd1, 5'd12);
    #1;
    chk("rs_stall_pre", 32'(Stall), 32'(hazOn));
    reset = 1'b0;
    #1;
    chk("rs_stall", 32'(Stall), 32'd0);
    chk("rs_cnt", 32'(BubbleCount), 32'd0);
    expCnt = 0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rs_add_valid", 32'(EX_Valid), 32'd1);
    chk("rs_add_writereg", 32'(EX_WriteReg), 32'd12);

    // Saturate the bubble counter with flushes
    Flush = 1'b1;
    tick();
    tick();
    chk("sat_cnt2", 32'(BubbleCount), 32'd2);
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_full", 32'(BubbleCount), 32'h0000_FFFF);
    tick();
    chk("sat_hold", 32'(BubbleCount), 32'h0000_FFFF);
    chk("sat_valid", 32'(EX_Valid), 32'd0);
    Flush = 1'b0;
    tick();
    chk("sat_after_valid", 32'(EX_Valid), 32'd1);
    chk("sat_after_cnt", 32'(BubbleCount), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
